// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: priority layer mux with blank-aligned RGB, per-frame move strobe, frame counter and score FSM.
// Define VGA_COMP_COLLIDE_EN to build the per-frame layer collision report on collide.
module vga_layer_compositor #(
    parameter int N_LAYERS  = 4,
    parameter int N_TARGETS = 12,
    parameter int SCORE_W   = 8,
    parameter int FRAME_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pixpulse,
    input  logic                   hblank,
    input  logic                   vblank,
    input  logic [N_LAYERS-1:0]    layer_draw,
    input  logic [12*N_LAYERS-1:0] layer_color,
    input  logic [11:0]            bg_color,
    input  logic [N_TARGETS-1:0]   broken,
    output logic [3:0]             vgaRed,
    output logic [3:0]             vgaGreen,
    output logic [3:0]             vgaBlue,
    output logic                   move,
    output logic [FRAME_W-1:0]     frame_cnt,
    output logic [SCORE_W-1:0]     score,
    output logic                   score_valid,
    output logic                   all_broken,
    output logic [N_LAYERS-1:0]    collide
);
    localparam int CW = $clog2(N_TARGETS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N_TARGETS - 1);
    localparam logic [SCORE_W-1:0] FULL = SCORE_W'(N_TARGETS);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    logic [11:0] sel, sel_nxt, rgb;
    logic blank_a, vblank_d;
    state_t state;
    logic [N_TARGETS-1:0] shreg;
    logic [SCORE_W-1:0] acc, acc_nxt;
    logic [CW-1:0] bit_cnt;

    // Walk from the lowest priority upward so the lowest-index drawn layer wins
    always_comb begin
        sel_nxt = bg_color;
        for (int i = N_LAYERS - 1; i >= 0; i--)
            if (layer_draw[i]) sel_nxt = layer_color[12*i +: 12];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel       <= '0;
            blank_a   <= 1'b0;
            rgb       <= '0;
            vblank_d  <= 1'b0;
            move      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            move <= pixpulse & vblank & ~vblank_d;
            if (move) frame_cnt <= frame_cnt + FRAME_W'(1);
            if (pixpulse) begin
                sel      <= sel_nxt;
                blank_a  <= hblank | vblank;
                rgb      <= blank_a ? 12'h000 : sel;
                vblank_d <= vblank;
            end
        end
    end

    assign {vgaRed, vgaGreen, vgaBlue} = rgb;
    assign acc_nxt = acc + {{(SCORE_W-1){1'b0}}, shreg[0]};

    // A move in any state restarts the count, which silently drops an unfinished one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            acc         <= '0;
            bit_cnt     <= '0;
            score       <= '0;
            score_valid <= 1'b0;
            all_broken  <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            if (move) begin
                state   <= COUNT;
                shreg   <= broken;
                acc     <= '0;
                bit_cnt <= '0;
            end else if (state == COUNT) begin
                acc     <= acc_nxt;
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + CW'(1);
                if (bit_cnt == LAST_BIT) begin
                    state       <= DONE;
                    score       <= acc_nxt;
                    score_valid <= 1'b1;
                    all_broken  <= acc_nxt == FULL;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

`ifdef VGA_COMP_COLLIDE_EN
    logic [N_LAYERS-1:0] col_acc, hits;
    // Two or more drawn layers on an active pixel mark every drawn layer as colliding
    assign hits = (pixpulse & ~hblank & ~vblank & |(layer_draw & (layer_draw - N_LAYERS'(1)))) ? layer_draw : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_acc <= '0;
            collide <= '0;
        end else begin
            col_acc <= move ? hits : (col_acc | hits);
            if (move) collide <= col_acc;
        end
    end
`else
    assign collide = '0;
`endif
endmodule

// File: tb/tb_vga_layer_compositor.sv
// tb_vga_layer_compositor: randomized and directed checks of vga_layer_compositor against a behavioural model.
module tb_vga_layer_compositor;
    localparam int NL = 4;
    localparam int NT = 12;
`ifdef VGA_COMP_COLLIDE_EN
    localparam logic [3:0] COL_EXP = 4'b0101;
`else
    localparam logic [3:0] COL_EXP = 4'b0000;
`endif

    logic clk = 1'b0;
    logic rst_n, pixpulse, hblank, vblank;
    logic [NL-1:0] layer_draw;
    logic [12*NL-1:0] layer_color;
    logic [11:0] bg_color;
    logic [NT-1:0] broken;
    logic [3:0] vgaRed, vgaGreen, vgaBlue;
    logic move, score_valid, all_broken;
    logic [15:0] frame_cnt;
    logic [7:0] score;
    logic [NL-1:0] collide;
    logic [11:0] rgb_out;

    int checks = 0, errors = 0, pc = 0, mv_cnt = 0, sv_cnt = 0;

    vga_layer_compositor dut (
        .clk(clk), .rst_n(rst_n), .pixpulse(pixpulse), .hblank(hblank), .vblank(vblank),
        .layer_draw(layer_draw), .layer_color(layer_color), .bg_color(bg_color), .broken(broken),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue), .move(move), .frame_cnt(frame_cnt),
        .score(score), .score_valid(score_valid), .all_broken(all_broken), .collide(collide)
    );

    assign rgb_out = {vgaRed, vgaGreen, vgaBlue};
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Colour a pixel must show: black in blanking, else first drawn layer, else background
    function automatic logic [11:0] pix_of(input logic [NL-1:0] d, input logic [12*NL-1:0] c,
                                           input logic [11:0] bg, input logic blank);
        logic [11:0] r;
        logic found;
        r = bg;
        found = 1'b0;
        for (int i = 0; i < NL; i++)
            if (d[i] && !found) begin
                r = c[12*i +: 12];
                found = 1'b1;
            end
        return blank ? 12'h000 : r;
    endfunction

    logic [11:0] m_q[$];
    logic [11:0] m_rgb;
    logic [15:0] m_frame;
    logic [7:0] m_score, m_pscore;
    logic [NL-1:0] m_cacc, m_col;
    logic m_move, m_pvb, m_valid, m_all;
    int m_edge, m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_rgb = '0; m_frame = '0; m_score = '0; m_pscore = '0; m_cacc = '0; m_col = '0;
            m_move = 0; m_pvb = 0; m_valid = 0; m_all = 0; m_edge = 0; m_pend = -1;
        end else begin
            m_edge++;
            if (m_move) begin
                m_frame++;
                m_pend = m_edge + NT;
                m_pscore = 8'($countones(broken));
`ifdef VGA_COMP_COLLIDE_EN
                m_col = m_cacc;
                m_cacc = '0;
`endif
            end
            m_valid = (m_edge == m_pend);
            if (m_valid) begin
                m_score = m_pscore;
                m_all = (m_pscore == NT);
            end
`ifdef VGA_COMP_COLLIDE_EN
            if (pixpulse && !hblank && !vblank && $countones(layer_draw) > 1) m_cacc |= layer_draw;
`endif
            m_move = pixpulse && vblank && !m_pvb;
            if (pixpulse) begin
                m_pvb = vblank;
                m_q.push_back(pix_of(layer_draw, layer_color, bg_color, hblank | vblank));
                if (m_q.size() > 2) void'(m_q.pop_front());
            end
            m_rgb = (m_q.size() == 2) ? m_q[0] : 12'h000;
        end
    end

    always @(negedge clk) begin
        chk("rgb", rgb_out, m_rgb);
        chk("move", move, m_move);
        chk("frame_cnt", frame_cnt, m_frame);
        chk("score", score, m_score);
        chk("score_valid", score_valid, m_valid);
        chk("all_broken", all_broken, m_all);
        chk("collide", collide, m_col);
        if (move) mv_cnt++;
        if (score_valid) sv_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        pixpulse = (pc == 0);
        pc = (pc + 1) % 4;
    endtask

    task automatic wait_pp();
        do tick(); while (!pixpulse);
    endtask

    task automatic wait_move(input string name);
        int n = 0;
        while (!move && n < 40) begin
            tick();
            n++;
        end
        chk(name, move, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!score_valid && lat < 40) begin
            tick();
            lat++;
            if (lat == 6) broken = 12'hfff;
        end
    endtask

    task automatic frame();
        vblank = 1'b1;
        repeat (8) tick();
        vblank = 1'b0;
        repeat (24) tick();
    endtask

    task automatic rand_inputs();
        layer_draw = NL'($urandom);
        hblank = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 11) == 0) vblank = ~vblank;
        if ($urandom_range(0, 49) == 0) broken = NT'($urandom);
        if ($urandom_range(0, 149) == 0) broken = '1;
        if ($urandom_range(0, 99) == 0) begin
            layer_color = {16'($urandom), 32'($urandom)};
            bg_color = 12'($urandom);
        end
    endtask

    initial begin
        int lat, m0, s0;
        rst_n = 1; pixpulse = 0; hblank = 0; vblank = 0; layer_draw = '0;
        layer_color = {12'h333, 12'h00f, 12'h0f0, 12'hf00}; bg_color = 12'h123; broken = '0;
        #1 rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
        repeat (300) begin
            rand_inputs();
            tick();
        end
        tick();
        #2 rst_n = 0;
        #1;
        chk("async_rst_rgb", rgb_out, 0);
        chk("async_rst_frame", frame_cnt, 0);
        chk("async_rst_score", {score, score_valid, all_broken, move}, 0);
        layer_draw = 4'b0001; layer_color[11:0] = 12'habc; hblank = 0; vblank = 0;
        repeat (6) tick();
        do tick(); while (pc != 2);
        rst_n = 1;
        wait_pp();
        @(posedge clk); #1 chk("rel_rgb_first_pp", rgb_out, 0);
        wait_pp();
        @(posedge clk); #1 chk("rel_rgb_second_pp", rgb_out, 12'habc);

        m0 = mv_cnt;
        repeat (3) frame();
        chk("three_moves", mv_cnt - m0, 3);
        chk("frame_cnt_3", frame_cnt, 3);

        layer_draw = 4'b0110; layer_color = {12'h333, 12'h00f, 12'h0f0, 12'hf00};
        repeat (12) tick();
        chk("rgb_layer1", rgb_out, 12'h0f0);
        layer_draw = '0; bg_color = 12'hfff;
        repeat (12) tick();
        chk("rgb_bg", rgb_out, 12'hfff);
        wait_pp();
        hblank = 1;
        @(posedge clk); #1 chk("hblank_pp1", rgb_out, 12'hfff);
        wait_pp();
        hblank = 0;
        @(posedge clk); #1 chk("hblank_pp2", rgb_out, 12'h000);
        wait_pp();
        @(posedge clk); #1 chk("hblank_pp3", rgb_out, 12'hfff);

        broken = 12'h0a5;
        wait_pp();
        vblank = 1;
        wait_move("score_move1");
        vblank = 0;
        wait_valid(lat);
        chk("score_latency", lat, 13);
        chk("score_0a5", score, 4);
        chk("all_broken_0a5", all_broken, 0);
        repeat (8) tick();
        wait_pp();
        vblank = 1;
        wait_move("score_move2");
        vblank = 0;
        wait_valid(lat);
        chk("score_fff", score, 12);
        chk("all_broken_fff", all_broken, 1);

        broken = 12'h0ff;
        repeat (8) tick();
        s0 = sv_cnt;
        wait_pp();
        vblank = 1;
        wait_move("abort_move1");
        vblank = 0;
        wait_pp();
        tick();
        broken = 12'h003;
        vblank = 1;
        wait_move("abort_move2");
        vblank = 0;
        repeat (40) tick();
        chk("abort_single_valid", sv_cnt - s0, 1);
        chk("abort_score", score, 2);

        layer_draw = '0;
        repeat (8) tick();
        frame();
        wait_pp();
        layer_draw = 4'b0101;
        tick();
        layer_draw = 4'b1000;
        repeat (8) tick();
        layer_draw = '0;
        wait_pp();
        vblank = 1;
        wait_move("col_move1");
        tick();
        chk("collide_overlap", collide, COL_EXP);
        vblank = 0;
        layer_draw = 4'b1000;
        repeat (12) tick();
        wait_pp();
        vblank = 1;
        wait_move("col_move2");
        tick();
        chk("collide_clear", collide, 0);
        vblank = 0;

        repeat (3000) begin
            rand_inputs();
            tick();
        end
        repeat (20) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
